// File: rtl/memory_responder.sv
// Wait-state memory slave: captures one request, optionally stalls WAIT_CYCLES,
// performs a single read or write on the memory array, then pulses ack.
module memory_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              do_access;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range  = (32'(addr_reg) < 32'(DEPTH));
    assign idx       = addr_reg[IDX_W-1:0];
    assign do_access = (state_reg == S_ACCESS);

    // State register plus the transaction capture; inputs are only sampled in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg == S_IDLE && req) begin
                addr_reg  <= addr;
                we_reg    <= we;
                wdata_reg <= wdata;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = S_ACCESS;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            S_ACCESS: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decode only flops, so ack/busy/err are glitch-free and input-independent.
    always_comb begin
        busy = (state_reg != S_IDLE);
        ack  = (state_reg == S_DONE);
        err  = (state_reg == S_DONE) && !in_range;
    end

    // Memory array is never reset; an async reset before ACCESS leaves it untouched.
    always_ff @(posedge clk) begin
        if (do_access && we_reg && in_range) begin
            mem[idx] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (do_access && !we_reg) begin
            rdata <= in_range ? mem[idx] : '0;
        end
    end

endmodule
